mult_carry_chain: RTL and testbench

MULT_CARRY_CHAIN -- requirements
Module: mult_carry_chain

---
 rtl/modexp_pkg.sv | 28 ++
 rtl/res_fifo3.sv | 47 ++++
 rtl/mult_carry_chain.sv | 136 +++++++++++++
 tb/tb_mult_carry_chain.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types for the word-serial multiply/carry chain: FSM encoding, word width, result-buffer entry.
package modexp_pkg;

  localparam int WORD_W = 16;
  localparam int PROD_W = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_TAIL,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] word;
  } res_ent_t;

  // Advance a pointer into the 3-entry buffer; a <= 2 and b <= 3 keep the sum below 6.
  function automatic logic [1:0] ptr_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/res_fifo3.sv
// 3-entry result buffer accepting one or two pushes per cycle; output is a registered entry, zero-latency pop.
module res_fifo3
  import modexp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push0,
  input  res_ent_t   i_dat0,
  input  logic       i_push1,
  input  res_ent_t   i_dat1,
  input  logic       i_pop,
  output res_ent_t   o_dat,
  output logic       o_vld,
  output logic [1:0] o_count
);

  res_ent_t   r_mem [3];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_count;
  logic [1:0] w_wr0;
  logic [1:0] w_wr1;
  logic       w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_wr0   = ptr_add(r_rd_ptr, r_count);
  // i_push1 only ever accompanies i_push0, so it lands one slot behind it.
  assign w_wr1   = ptr_add(r_rd_ptr, r_count + 2'd1);
  assign o_dat   = r_mem[r_rd_ptr];
  assign o_vld   = (r_count != 2'd0);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_push0) r_mem[w_wr0] <= i_dat0;
    if (i_push1) r_mem[w_wr1] <= i_dat1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= ptr_add(r_rd_ptr, 2'd1);
      r_count <= r_count + 2'(i_push0) + 2'(i_push1) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/mult_carry_chain.sv
// Sequences an external mult16 over WORDS operand words, feeding each carry back through c and
// streaming result words (plus a final carry word) through a 3-entry buffer with valid/ready.
module mult_carry_chain
  import modexp_pkg::*;
#(
  parameter int WORDS = 64,
  parameter int IDXW  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [IDXW-1:0]   o_word_idx,
  output logic              o_ce_out,
  output logic [PROD_W-1:0] o_c_out,
  input  logic [PROD_W-1:0] i_p,
  output logic [WORD_W-1:0] o_res_word,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_last,
  output logic              o_busy,
  output logic              o_ovf
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_idx_nxt;
  logic            r_ovf;
  logic            w_room;
  logic            w_ce;
  logic            w_push0;
  logic            w_push1;
  res_ent_t        w_dat0;
  res_ent_t        w_dat1;
  res_ent_t        w_head;
  logic            w_fifo_vld;
  logic [1:0]      w_fifo_count;

  // Reset asserts immediately, releases two clock edges later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Only issue when a worst-case (TAIL) double push still fits.
  assign w_room = (w_fifo_count <= 2'd1);

  assign w_dat0.last = 1'b0;
  assign w_dat0.word = i_p[15:0];
  assign w_dat1.last = 1'b1;
  assign w_dat1.word = i_p[31:16];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ce        = 1'b0;
    w_push0     = 1'b0;
    w_push1     = 1'b0;
    o_c_out     = '0;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt = '0;
        if (i_start) w_state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        w_ce = w_room;
        if (w_room) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = IDXW'(1);
        end
      end
      ST_RUN: begin
        w_ce    = w_room;
        w_push0 = w_room;
        o_c_out = {16'h0, i_p[35:16]};
        if (w_room) begin
          if (r_idx == LAST_IDX) w_state_nxt = ST_TAIL;
          else                   w_idx_nxt   = r_idx + IDXW'(1);
        end
      end
      ST_TAIL: begin
        w_ce    = w_room;
        w_push0 = w_room;
        w_push1 = w_room;
        if (w_room) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!w_fifo_vld) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == ST_IDLE && i_start)                      r_ovf <= 1'b0;
      else if (r_state == ST_TAIL && w_ce && i_p[35:32] != 4'h0) r_ovf <= 1'b1;
    end
  end

  res_fifo3 u_res_fifo3 (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_push0 (w_push0),
    .i_dat0  (w_dat0),
    .i_push1 (w_push1),
    .i_dat1  (w_dat1),
    .i_pop   (i_res_ready),
    .o_dat   (w_head),
    .o_vld   (w_fifo_vld),
    .o_count (w_fifo_count)
  );

  assign o_word_idx  = r_idx;
  assign o_ce_out    = w_ce;
  assign o_res_word  = w_head.word;
  assign o_res_last  = w_head.last && w_fifo_vld;
  assign o_res_valid = w_fifo_vld;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_mult_carry_chain.sv
// Bench for mult_carry_chain (WORDS=4) with a behavioural mult16 (registered a/b/c, combinational p).
module tb_mult_carry_chain;

  localparam int W = 4;

  typedef struct packed {
    logic        last;
    logic [15:0] word;
  } exp_t;

  typedef struct packed {
    logic [W-1:0][15:0] a;
    logic [15:0]        b;
    logic [W:0][15:0]   r;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        res_ready;
  logic [9:0]  word_idx;
  logic        ce_out;
  logic [35:0] c_out;
  logic [35:0] p;
  logic [15:0] res_word;
  logic        res_valid;
  logic        res_last;
  logic        busy;
  logic        ovf;

  logic [W-1:0][15:0] a_vec;
  logic [15:0]        b_val;
  bit                 force_ovf;
  bit                 rdy_toggle;
  logic [15:0]        a_r;
  logic [15:0]        b_r;
  logic [35:0]        c_r;

  vec_t tbl [7];
  exp_t sb [$];
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   start_cyc;
  int   first_cyc;
  int   last_cyc;
  int   ce_cnt;
  int   pops;
  int   ce_viol;

  mult_carry_chain #(.WORDS(W), .IDXW(10)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .o_word_idx  (word_idx),
    .o_ce_out    (ce_out),
    .o_c_out     (c_out),
    .i_p         (p),
    .o_res_word  (res_word),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_last  (res_last),
    .o_busy      (busy),
    .o_ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mult16 stand-in; force_ovf injects bit 32 into c for the last word so TAIL sees p[35:32]=1.
  always @(posedge clk) begin
    if (ce_out) begin
      a_r <= a_vec[word_idx[1:0]];
      b_r <= b_val;
      c_r <= c_out | ((force_ovf && word_idx == 10'(W - 1)) ? 36'h1_0000_0000 : 36'h0);
    end
  end
  assign p = {20'h0, a_r} * {20'h0, b_r} + c_r;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0][15:0] ref_mul(input logic [W-1:0][15:0] a, input logic [15:0] b);
    logic [W:0][15:0] r;
    logic [35:0]      t;
    logic [19:0]      c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      t    = {20'h0, a[i]} * {20'h0, b} + {16'h0, c};
      r[i] = t[15:0];
      c    = t[35:16];
    end
    r[W] = c[15:0];
    return r;
  endfunction

  task automatic ready_drv();
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rdy_toggle ? ~res_ready : 1'b1;
    end
  endtask

  // Occupancy model: ce #1 (PRIME) pushes nothing, ce #2..#W push one, ce #W+1 (TAIL) pushes two.
  task automatic monitor();
    int   pushes;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (rst_n) begin
        pushes = (ce_cnt <= 1) ? 0 : ((ce_cnt <= W) ? ce_cnt - 1 : W + 1);
        if (ce_out && (pushes - pops) >= 2) ce_viol++;
        if (int'(word_idx) > W - 1) ce_viol++;
        if (ce_out) ce_cnt++;
        if (res_valid && first_cyc < 0) first_cyc = cyc;
        if (res_valid && res_ready) begin
          pops++;
          last_cyc = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_word", longint'(res_word), -1);
          end else begin
            e = sb.pop_front();
            chk("res_word", longint'(res_word), longint'(e.word));
            chk("res_last", longint'(res_last), longint'(e.last));
          end
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idx"},   longint'(word_idx),  0);
    chk({tag, "_ce"},    longint'(ce_out),    0);
    chk({tag, "_c"},     longint'(c_out),     0);
    chk({tag, "_valid"}, longint'(res_valid), 0);
    chk({tag, "_last"},  longint'(res_last),  0);
    chk({tag, "_busy"},  longint'(busy),      0);
    chk({tag, "_ovf"},   longint'(ovf),       0);
  endtask

  // inject: 0 none, 1 start pulse at word_idx 2, 2 reset at word_idx 2.
  task automatic run_pass(input int vi, input bit chk_tput, input bit exp_ovf, input int inject);
    exp_t e;
    bit   done;
    bit   aborted;
    bit   injected;
    a_vec = tbl[vi].a;
    b_val = tbl[vi].b;
    @(posedge clk);
    #1;
    ce_cnt = 0; pops = 0; ce_viol = 0; first_cyc = -1; last_cyc = -1;
    for (int i = 0; i <= W; i++) begin
      e.last = (i == W);
      e.word = tbl[vi].r[i];
      sb.push_back(e);
    end
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("prime_busy", longint'(busy), 1);
    chk("prime_idx", longint'(word_idx), 0);
    chk("prime_ovf_clr", longint'(ovf), 0);
    done = 0; aborted = 0; injected = 0;
    for (int k = 0; k < 200 && !done && !aborted; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (inject != 0 && !injected && busy && word_idx == 10'd2) begin
        injected = 1;
        if (inject == 1) begin
          start = 1'b1;
        end else begin
          rst_n = 1'b0;
          #1;
          chk_reset_outputs("midrst");
          sb.delete();
          repeat (2) @(posedge clk);
          #1;
          chk("midrst_hold_valid", longint'(res_valid), 0);
          rst_n = 1'b1;
          repeat (4) @(posedge clk);
          #1;
          chk("midrst_release_busy", longint'(busy), 0);
          aborted = 1;
        end
      end
      if (!aborted && !busy && sb.size() == 0) done = 1;
    end
    if (!aborted) begin
      chk("pass_done", longint'(done), 1);
      chk("ovf", longint'(ovf), longint'(exp_ovf));
      chk("ce_count", ce_cnt, W + 1);
      chk("ce_room_idx", ce_viol, 0);
      chk("xfer_count", pops, W + 1);
      if (chk_tput) begin
        // start is captured one edge after start_cyc; first word is valid two edges later.
        chk("first_valid_lat", first_cyc - start_cyc, 3);
        chk("burst_span", last_cyc - first_cyc, W);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    ce_cnt = 0; pops = 0; ce_viol = 0; first_cyc = -1; last_cyc = -1; start_cyc = 0;
    rst_n = 1'b1; start = 1'b0; force_ovf = 0; rdy_toggle = 0;
    a_vec = '0; b_val = '0;

    tbl[0].a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tbl[0].b = 16'h0002;
    tbl[0].r = {16'h0000, 16'h0008, 16'h0006, 16'h0004, 16'h0002};
    tbl[1].a = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[1].b = 16'hFFFF;
    tbl[1].r = {16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001};
    tbl[2].a = '0;
    tbl[2].b = 16'h1234;
    tbl[2].r = '0;
    tbl[3].a = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tbl[3].b = 16'h0002;
    tbl[3].r = {16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
    tbl[4].a = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
    tbl[4].b = 16'h0100;
    tbl[4].r = {16'h0000, 16'h0000, 16'h0000, 16'h0012, 16'h3400};
    for (int v = 5; v < 7; v++) begin
      for (int j = 0; j < W; j++) tbl[v].a[j] = 16'($urandom);
      tbl[v].b = 16'($urandom);
      tbl[v].r = ref_mul(tbl[v].a, tbl[v].b);
    end

    fork
      monitor();
      ready_drv();
      begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
      end
    join_none

    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int v = 0; v < 7; v++) run_pass(v, 1'b1, 1'b0, 0);

    rdy_toggle = 1;
    run_pass(1, 1'b0, 1'b0, 0);
    rdy_toggle = 0;

    force_ovf = 1;
    run_pass(0, 1'b1, 1'b1, 0);
    force_ovf = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", longint'(ovf), 1);
    run_pass(0, 1'b1, 1'b0, 0);

    run_pass(2, 1'b1, 1'b0, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("restart_ignored_idle", longint'(busy), 0);

    run_pass(1, 1'b0, 1'b0, 2);
    run_pass(1, 1'b1, 1'b0, 0);

    repeat (5) @(posedge clk);
    chk("sb_empty", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
